// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter giving two requesters access to one single-port synchronous RAM.
// Define MEM_PORT_ARBITER_SCAN_EN to add a background read scan that runs while no requester is waiting.
module mem_port_arbiter #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              scan_valid,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;

    state_t            state, state_nx;
    logic              last_b, win_b, is_scan, op_we;
    logic              go, start, scan_go, pick_b, sel_we;
    logic [ADDR_W-1:0] scan_ptr;

`ifdef MEM_PORT_ARBITER_SCAN_EN
    localparam logic SCAN_EN = 1'b1;
`else
    localparam logic SCAN_EN = 1'b0;
`endif

    // Arbitration: B wins alone or on a tie when A was granted last; an idle slot becomes a scan when enabled
    always_comb begin
        pick_b  = req_b && (!req_a || !last_b);
        go      = !hold && (req_a || req_b || SCAN_EN);
        start   = (state == IDLE) && go;
        scan_go = go && !req_a && !req_b;
        sel_we  = !scan_go && (pick_b ? we_b : we_a);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: ISSUE and COMPLETE are fixed single cycles
    always_comb begin
        state_nx = (state == IDLE) ? (go ? ISSUE : IDLE) : (state == ISSUE) ? COMPLETE : IDLE;
    end

    // RAM command registers and the record of who owns the access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            win_b     <= 1'b0;
            is_scan   <= 1'b0;
            op_we     <= 1'b0;
            last_b    <= 1'b1;
        end else begin
            mem_en <= start;
            mem_we <= start && sel_we;
            if (start) begin
                mem_addr  <= scan_go ? scan_ptr : pick_b ? addr_b : addr_a;
                mem_wdata <= scan_go ? '0 : pick_b ? wdata_b : wdata_a;
                op_we     <= sel_we;
                win_b     <= pick_b;
                is_scan   <= scan_go;
                if (!scan_go) last_b <= pick_b;
            end
        end
    end

    // Completion outputs: only the owner of the access sees ack and read data
    always_comb begin
        busy    = state != IDLE;
        ack_a   = (state == COMPLETE) && !is_scan && !win_b;
        ack_b   = (state == COMPLETE) && !is_scan && win_b;
        rdata_a = (ack_a && !op_we) ? mem_rdata : '0;
        rdata_b = (ack_b && !op_we) ? mem_rdata : '0;
    end

`ifdef MEM_PORT_ARBITER_SCAN_EN
    // Scan pointer advances once each scan read completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             scan_ptr <= '0;
        else if ((state == COMPLETE) && is_scan) scan_ptr <= scan_ptr + ADDR_W'(1);
    end

    // Scan result is presented during the scan's COMPLETE cycle
    always_comb begin
        scan_valid = (state == COMPLETE) && is_scan;
        scan_addr  = scan_valid ? scan_ptr : '0;
        scan_data  = scan_valid ? mem_rdata : '0;
    end
`else
    assign scan_ptr   = '0;
    assign scan_valid = 1'b0;
    assign scan_addr  = '0;
    assign scan_data  = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int DW = 4;
    localparam int AW = 2;
`ifdef MEM_PORT_ARBITER_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, hold = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          ack_a, ack_b, mem_en, mem_we, busy, scan_valid;
    logic [DW-1:0] rdata_a, rdata_b, mem_wdata, scan_data;
    logic [AW-1:0] mem_addr, scan_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] ram [4];

    int checks = 0, failures = 0;

    // reference model state
    int            n = 0, s_n = 0, kind = 0;
    bit            act = 1'b0, m_last_b = 1'b1, sticky = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0, m_ptr = '0;
    logic [DW-1:0] m_wdata = '0, m_rd = '0;
    logic [DW-1:0] sh [4];

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy),
        .scan_valid(scan_valid), .scan_addr(scan_addr), .scan_data(scan_data)
    );

    // single-port synchronous RAM
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        act      = 1'b0;
        m_last_b = 1'b1;
        m_ptr    = '0;
    endtask

    // An access accepted at edge s_n is in ISSUE after s_n, COMPLETE after s_n+1, idle after s_n+2
    task automatic model_edge();
        n++;
        if (act) begin
            if (n - s_n == 2) act = 1'b0;
        end else if (!hold && (req_a || req_b || SCAN)) begin
            act = 1'b1;
            s_n = n;
            if (req_a && req_b) kind = m_last_b ? 0 : 1;
            else if (req_a)     kind = 0;
            else if (req_b)     kind = 1;
            else                kind = 2;
            m_we    = kind == 0 ? we_a : kind == 1 ? we_b : 1'b0;
            m_addr  = kind == 0 ? addr_a : kind == 1 ? addr_b : m_ptr;
            m_wdata = kind == 0 ? wdata_a : kind == 1 ? wdata_b : '0;
            m_rd    = sh[m_addr];
            if (m_we) sh[m_addr] = m_wdata;
            if (kind < 2) m_last_b = kind == 1;
            else          m_ptr = m_ptr + 1'b1;
        end
    endtask

    task automatic compare();
        int ph;
        ph = act ? n - s_n : -1;
        check("busy", busy, act);
        check("mem_en", mem_en, ph == 0);
        check("mem_we", mem_we, ph == 0 && m_we);
        if (ph == 0) check("mem_addr", mem_addr, m_addr);
        if (ph == 0 && m_we) check("mem_wdata", mem_wdata, m_wdata);
        check("ack_a", ack_a, ph == 1 && kind == 0);
        check("ack_b", ack_b, ph == 1 && kind == 1);
        check("rdata_a", rdata_a, (ph == 1 && kind == 0 && !m_we) ? m_rd : '0);
        check("rdata_b", rdata_b, (ph == 1 && kind == 1 && !m_we) ? m_rd : '0);
        check("scan_valid", scan_valid, ph == 1 && kind == 2);
`ifdef MEM_PORT_ARBITER_SCAN_EN
        if (ph == 1 && kind == 2) begin
            check("scan_addr", scan_addr, m_addr);
            check("scan_data", scan_data, m_rd);
        end
`else
        check("scan_addr_tied", scan_addr, 0);
        check("scan_data_tied", scan_data, 0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        if (ack_a && !sticky) req_a = 1'b0;
        if (ack_b && !sticky) req_b = 1'b0;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            ram[i] = DW'(i + 1);
            sh[i]  = DW'(i + 1);
        end
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_scan_valid", scan_valid, 0);
        #11 rst_n = 1'b1;
        model_reset();
        // idle window: background scan when compiled in, otherwise nothing happens
        run(14);
        // write A then read it back through B
        req_a = 1'b1; we_a = 1'b1; addr_a = 2'd2; wdata_a = 4'd9;
        run(6);
        req_b = 1'b1; we_b = 1'b0; addr_b = 2'd2;
        run(6);
        // both requesting continuously: grants alternate
        sticky = 1'b1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 2'd1;
        req_b = 1'b1; we_b = 1'b0; addr_b = 2'd3;
        run(10);
        sticky = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        run(4);
        // hold blocks new grants
        hold = 1'b1; req_a = 1'b1; we_a = 1'b0; addr_a = 2'd0;
        run(5);
        hold = 1'b0;
        run(5);
        // reset during ISSUE aborts the access
        req_a = 1'b1; we_a = 1'b0; addr_a = 2'd1;
        for (int i = 0; i < 8 && !(act && n == s_n && kind == 0); i++) step();
        check("issue_before_rst", mem_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_en", mem_en, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ack_a", ack_a, 0);
        req_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        run(6);
        // randomized traffic
        repeat (600) begin
            hold = $urandom_range(0, 7) == 0;
            if (!req_a && $urandom_range(0, 2) == 0) begin
                req_a = 1'b1; we_a = 1'($urandom); addr_a = AW'($urandom); wdata_a = DW'($urandom);
            end else if (req_a && $urandom_range(0, 30) == 0) req_a = 1'b0;
            if (!req_b && $urandom_range(0, 2) == 0) begin
                req_b = 1'b1; we_b = 1'($urandom); addr_b = AW'($urandom); wdata_b = DW'($urandom);
            end else if (req_b && $urandom_range(0, 30) == 0) req_b = 1'b0;
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, memory word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 2, memory address width (2^ADDR_W words).
REQ-003 Clock  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 hold  input  1  1 = no new grant issued; an in-flight access still completes.
REQ-006 req_a, req_b  input  1 each  access request from requester A / B; held high until ack.
REQ-007 we_a, we_b  input  1 each  1 = write, 0 = read.
REQ-008 addr_a, addr_b  input  ADDR_W each  target word address.
REQ-009 wdata_a, wdata_b  input  DATA_W each  write data.
REQ-010 ack_a, ack_b  output  1 each  one-cycle completion pulse to the granted requester.
REQ-011 rdata_a, rdata_b  output  DATA_W each  read data, valid only while the matching ack is high.
REQ-012 mem_en, mem_we  output  1 each  registered enable / write strobe to single-port synchronous RAM.
REQ-013 mem_addr  output  ADDR_W  and  mem_wdata  output  DATA_W  registered RAM address / write data.
REQ-014 mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en=1, mem_we=0.
REQ-015 busy  output  1  1 whenever the FSM is not IDLE.
REQ-016 scan_valid  output  1,  scan_addr  output  ADDR_W,  scan_data  output  DATA_W  background-scan result (see Configuration).

Function
REQ-017 The FSM SHALL have three states: IDLE, ISSUE, COMPLETE; ISSUE and COMPLETE each last exactly one cycle.
REQ-018 IDLE->ISSUE SHALL occur when hold=0 and (req_a or req_b); otherwise IDLE is held.
REQ-019 On IDLE->ISSUE the winner's we/addr/wdata SHALL be registered onto mem_we/mem_addr/mem_wdata with mem_en=1 during ISSUE.
REQ-020 Single request: that requester SHALL win; both requesting: the requester not granted last SHALL win (round-robin).
REQ-021 The last-grant register SHALL update only on IDLE->ISSUE for requester grants.
REQ-022 ISSUE->COMPLETE unconditionally; in COMPLETE mem_en=0, the winner's ack SHALL be 1 and, for a read, its rdata SHALL equal mem_rdata.
REQ-023 COMPLETE->IDLE unconditionally; request-to-ack latency SHALL be 2 cycles from the IDLE sampling edge; max throughput one access per 3 cycles.
REQ-024 Inputs SHALL be ignored outside IDLE; deasserting req during ISSUE/COMPLETE SHALL NOT abort or suppress the ack.
REQ-025 The non-granted requester's ack SHALL stay 0; its rdata SHALL be 0.
REQ-026 hold rising during ISSUE or COMPLETE SHALL NOT affect the current access.

Reset
REQ-027 Reset=0 SHALL force IDLE, last-grant=B (so A wins the first tie), all outputs 0, scan address 0.
REQ-028 Reset mid-access SHALL abort it with no ack; mem_en SHALL drop asynchronously.

Configuration
REQ-029 Macro MEM_PORT_ARBITER_SCAN_EN SHALL compile in background scan; absent, scan_valid/scan_addr/scan_data SHALL be tied 0.
REQ-030 With the macro: in IDLE with hold=0 and no requests, a read of the internal scan address SHALL be issued via ISSUE/COMPLETE.
REQ-031 In the scan COMPLETE cycle scan_valid=1, scan_addr=scanned address, scan_data=mem_rdata; no ack asserted.
REQ-032 The scan address SHALL increment after each scan, wrapping 2^ADDR_W-1 -> 0; scans SHALL NOT update last-grant.
REQ-033 Requests SHALL have priority over scan; a request arriving during a scan access waits for return to IDLE.

Verification
REQ-034 Write A: req_a=1, we_a=1, addr_a=2, wdata_a=9 -> ISSUE: mem_en=1, mem_we=1, mem_addr=2, mem_wdata=9; ack_a pulse 2 cycles later.
REQ-035 Read B after it: req_b=1, we_b=0, addr_b=2 -> ack_b=1 with rdata_b=9, ack_a=0.
REQ-036 Tie after reset: req_a=req_b=1 held -> grants A, B, A in turn, acks every 3 cycles.
REQ-037 hold=1 with req_a=1 for 5 cycles -> mem_en stays 0, busy 0; hold=0 -> ack_a 2 cycles later.
REQ-038 Reset=0 during ISSUE -> immediately mem_en=0, busy=0; no ack after release.
REQ-039 With MEM_PORT_ARBITER_SCAN_EN, RAM preloaded 1,2,3,4, no requests -> scan_valid pulses every 3 cycles, scan_addr 0,1,2,3,0 with scan_data 1,2,3,4,1.
